// File: rtl/chunk_adder_if.sv
// Operand/result bundle for chunk_adder: start/busy/done handshake plus data.
interface chunk_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered carry,
// reporting carry-out and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | adding chunk k each edge; last chunk publishes results
module chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic         clk,
  input logic         rst,
  chunk_adder_if.slave io
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             accept, last;
  logic [WIDTH-1:0] op_a, op_b, work, work_nxt, s_q;
  logic             carry, cout_q, ovf_q, done_q;
  logic [KW-1:0]    k;
  logic [31:0]      sh;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (io.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (k == KW'(N - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sh        = 32'(k) * 32'(CHUNK);
    a_chunk   = CHUNK'(op_a >> sh);
    b_chunk   = CHUNK'(op_b >> sh);
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry);
    work_nxt  = (work & ~(CMASK << sh)) | (WIDTH'(chunk_sum[CHUNK-1:0]) << sh);
  end

  // Carry into the MSB comes from inside the top chunk, not its boundary.
  generate
    if (CHUNK == 1) begin : g_msb_single
      assign msb_cin = carry;
    end else begin : g_msb_multi
      logic [CHUNK-1:0] lo_sum;
      assign lo_sum  = {1'b0, a_chunk[CHUNK-2:0]} + {1'b0, b_chunk[CHUNK-2:0]}
                     + CHUNK'(carry);
      assign msb_cin = lo_sum[CHUNK-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      work   <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        op_a  <= io.a;
        op_b  <= io.sub ? ~io.b : io.b;
        carry <= io.sub | io.cin;
        k     <= '0;
      end else if (state == RUN) begin
        work  <= work_nxt;
        carry <= chunk_sum[CHUNK];
        k     <= last ? '0 : k + 1'b1;
        if (last) begin
          s_q    <= work_nxt;
          cout_q <= chunk_sum[CHUNK];
          ovf_q  <= chunk_sum[CHUNK] ^ msb_cin;
        end
      end
    end
  end

  assign io.busy = (state == RUN);
  assign io.done = done_q;
  assign io.s    = s_q;
  assign io.cout = cout_q;
  assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_chunk_adder.sv
// Bench for chunk_adder: CHUNK = 1, 2, 4, 8 instances share stimulus; index 1
// (CHUNK=2) carries the handshake and reset scenarios.
module tb_chunk_adder;
  logic clk, rst;
  logic start_v, sub_v, cin_v;
  logic [7:0] a_v, b_v;

  logic [3:0] busy_w, done_w, cout_w, ovf_w;
  logic [7:0] s_w [4];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g
    chunk_adder_if #(.WIDTH(8)) io ();
    chunk_adder #(.WIDTH(8), .CHUNK(1 << gi)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
    );
    assign io.start   = start_v;
    assign io.sub     = sub_v;
    assign io.cin     = cin_v;
    assign io.a       = a_v;
    assign io.b       = b_v;
    assign busy_w[gi] = io.busy;
    assign done_w[gi] = io.done;
    assign cout_w[gi] = io.cout;
    assign ovf_w[gi]  = io.ovf;
    assign s_w[gi]    = io.s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, s}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic sub, input logic cin);
    int sa, sb, r, ua, ub, u;
    logic [7:0] s;
    logic cout, ovf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    if (sub) begin
      r    = sa - sb;
      u    = (ua - ub + 256) % 256;
      cout = (ua >= ub);
    end else begin
      r    = sa + sb + int'(cin);
      u    = (ua + ub + int'(cin)) % 256;
      cout = (ua + ub + int'(cin)) > 255;
    end
    s   = u[7:0];
    ovf = (r > 127) || (r < -128);
    return {ovf, cout, s};
  endfunction

  task automatic drain();
    @(negedge clk);
    start_v = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // One operation on all four instances; checks each against the model.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tsub,
                        input logic tcin, output logic [7:0] rs, output logic rc,
                        output logic ro);
    int lat [4];
    int ndone [4];
    int nbusy [4];
    logic [7:0] cs [4];
    logic cc [4];
    logic co [4];
    logic [9:0] exp;
    @(negedge clk);
    a_v = ta; b_v = tb; sub_v = tsub; cin_v = tcin; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1; ndone[i] = 0; nbusy[i] = int'(busy_w[i]);
      cs[i] = 8'h00; cc[i] = 1'b0; co[i] = 1'b0;
      if (done_w[i]) ndone[i]++;
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (busy_w[i]) nbusy[i]++;
        if (done_w[i]) begin
          ndone[i]++;
          if (ndone[i] == 1) begin
            lat[i] = cyc; cs[i] = s_w[i]; cc[i] = cout_w[i]; co[i] = ovf_w[i];
          end
        end
      end
    end
    exp = model(ta, tb, tsub, tcin);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lat_c%0d", 1 << i), 32'(lat[i] + 1), 32'((8 >> i) + 1));
      check($sformatf("ndone_c%0d", 1 << i), 32'(ndone[i]), 32'd1);
      check($sformatf("nbusy_c%0d", 1 << i), 32'(nbusy[i]), 32'(8 >> i));
      check($sformatf("s_c%0d a=%h b=%h sub=%b cin=%b", 1 << i, ta, tb, tsub, tcin),
            32'(cs[i]), 32'(exp[7:0]));
      check($sformatf("cout_c%0d a=%h b=%h sub=%b", 1 << i, ta, tb, tsub), 32'(cc[i]),
            32'(exp[8]));
      check($sformatf("ovf_c%0d a=%h b=%h sub=%b", 1 << i, ta, tb, tsub), 32'(co[i]),
            32'(exp[9]));
    end
    rs = cs[1]; rc = cc[1]; ro = co[1];
  endtask

  initial begin
    logic [7:0] rs;
    logic rc, ro;
    logic [7:0] corner [4];
    int nd, d1, d2;
    logic [7:0] s_d1, s_d2;

    rst = 1'b1; start_v = 1'b0; sub_v = 1'b0; cin_v = 1'b0; a_v = '0; b_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy_c%0d", 1 << i), 32'(busy_w[i]), 32'd0);
      check($sformatf("rst_done_c%0d", 1 << i), 32'(done_w[i]), 32'd0);
      check($sformatf("rst_s_c%0d", 1 << i), 32'(s_w[i]), 32'd0);
      check($sformatf("rst_cout_c%0d", 1 << i), 32'(cout_w[i]), 32'd0);
      check($sformatf("rst_ovf_c%0d", 1 << i), 32'(ovf_w[i]), 32'd0);
    end

    // Directed cases with hand-computed results
    run_op(8'hF6, 8'h7D, 1'b0, 1'b0, rs, rc, ro);
    check("dir_f6_7d", 32'({ro, rc, rs}), 32'({1'b0, 1'b1, 8'h73}));
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro);
    check("dir_7f_01", 32'({ro, rc, rs}), 32'({1'b1, 1'b0, 8'h80}));
    run_op(8'hFF, 8'h00, 1'b0, 1'b1, rs, rc, ro);
    check("dir_ff_00_cin", 32'({ro, rc, rs}), 32'({1'b0, 1'b1, 8'h00}));
    run_op(8'h05, 8'h07, 1'b1, 1'b0, rs, rc, ro);
    check("dir_05_sub_07", 32'({ro, rc, rs}), 32'({1'b0, 1'b0, 8'hFE}));
    run_op(8'h80, 8'h01, 1'b1, 1'b1, rs, rc, ro);
    check("dir_80_sub_01", 32'({ro, rc, rs}), 32'({1'b1, 1'b1, 8'h7F}));

    // Start while busy is ignored (CHUNK=2)
    @(negedge clk);
    a_v = 8'h12; b_v = 8'h34; sub_v = 1'b0; cin_v = 1'b0; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    nd = 0; d1 = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        a_v = 8'hAA; b_v = 8'h55; sub_v = 1'b1; start_v = 1'b1;
      end else begin
        start_v = 1'b0;
      end
      if (done_w[1]) begin
        nd++;
        if (d1 < 0) d1 = cyc;
      end
    end
    check("ign_ndone", 32'(nd), 32'd1);
    check("ign_lat", 32'(d1), 32'd4);
    check("ign_s", 32'(s_w[1]), 32'h46);
    drain();

    // Start held high: back-to-back accept in the done cycle
    @(negedge clk);
    a_v = 8'h10; b_v = 8'h20; sub_v = 1'b0; cin_v = 1'b0; start_v = 1'b1;
    @(negedge clk);
    a_v = 8'h40; b_v = 8'h05; sub_v = 1'b1;
    d1 = -1; d2 = -1; s_d1 = '0; s_d2 = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 10) start_v = 1'b0;
      if (cyc == 7) check("b2b_hold_s", 32'(s_w[1]), 32'h30);
      if (done_w[1]) begin
        if (d1 < 0) begin
          d1 = cyc; s_d1 = s_w[1];
        end else if (d2 < 0) begin
          d2 = cyc; s_d2 = s_w[1];
        end
      end
    end
    check("b2b_first_done", 32'(d1), 32'd4);
    check("b2b_spacing", 32'(d2 - d1), 32'd5);
    check("b2b_s1", 32'(s_d1), 32'h30);
    check("b2b_s2", 32'(s_d2), 32'h3B);
    drain();

    // Reset on the third RUN cycle aborts the operation
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro);
    @(negedge clk);
    a_v = 8'h55; b_v = 8'h22; sub_v = 1'b0; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy_w[1]), 32'd0);
    check("rst_mid_s", 32'(s_w[1]), 32'd0);
    check("rst_mid_cout", 32'(cout_w[1]), 32'd0);
    check("rst_mid_ovf", 32'(ovf_w[1]), 32'd0);
    check("rst_mid_done", 32'(done_w[1]), 32'd0);
    nd = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (done_w[1]) nd++;
    end
    check("rst_mid_nodone", 32'(nd), 32'd0);
    run_op(8'hF6, 8'h7D, 1'b0, 1'b0, rs, rc, ro);
    check("rst_after_op", 32'({ro, rc, rs}), 32'({1'b0, 1'b1, 8'h73}));

    // Corner operands, every mode
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int m = 0; m < 4; m++)
          run_op(corner[ia], corner[ib], m[1], m[0], rs, rc, ro);

    // Random sweep
    for (int n = 0; n < 1500; n++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), rs, rc, ro);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
